// File: rtl/cic_pkg.sv
// Shared CIC helpers: accumulator sizing, parameter limits and input-mode selection.
package cic_pkg;

  localparam int CIC_MAX_ORDER = 6;
  localparam int CIC_MAX_DECIM = 4096;

  typedef enum logic {
    CIC_MODE_PDM = 1'b0,
    CIC_MODE_PCM = 1'b1
  } cic_mode_e;

  function automatic int cic_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic cic_mode_e cic_mode(input int in_w);
    return (in_w == 1) ? CIC_MODE_PDM : CIC_MODE_PCM;
  endfunction

  // PDM bits become +/-1, which needs two bits of signed range.
  function automatic int cic_acc_width(input int in_w, input int order,
                                       input int decim, input int diff_delay);
    int in_eff;
    in_eff = (in_w == 1) ? 2 : in_w;
    return in_eff + order * cic_clog2(decim * diff_delay);
  endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Sample-in / decimated-out bundle; master drives samples, slave is the filter.
interface cic_decimator_if #(
  parameter int IN_W  = 1,
  parameter int OUT_W = 24
);
  logic                    in_valid;
  logic [IN_W-1:0]         din;
  logic                    phase_clr;
  logic                    out_valid;
  logic signed [OUT_W-1:0] dout;

  modport master (output in_valid, din, phase_clr, input out_valid, dout);
  modport slave  (input in_valid, din, phase_clr, output out_valid, dout);
endinterface

// File: rtl/cic_comb_stage.sv
// One comb section y = x - x[-M]; result registered, delay line shifts only on en.
module cic_comb_stage #(
  parameter int W          = 16,
  parameter int DIFF_DELAY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] y
);

  logic signed [DIFF_DELAY-1:0][W-1:0] dly;

  always_ff @(posedge clk) begin
    if (reset) begin
      y   <= '0;
      dly <= '0;
    end else if (en) begin
      y      <= x - dly[DIFF_DELAY-1];
      dly[0] <= x;
      for (int i = 1; i < DIFF_DELAY; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator; dout/out_valid register ORDER+1 edges after the block-completing sample.
// No backpressure: accepts a sample whenever in_valid is high. Rounding/saturation under CIC_ROUND_EN.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int IN_W       = 1,
  parameter int ORDER      = 2,
  parameter int DECIM      = 49,
  parameter int DIFF_DELAY = 1,
  parameter int OUT_W      = 24
) (
  input logic             clk,
  input logic             reset,
  cic_decimator_if.slave  bus
);

  localparam int        ACC_W = cic_acc_width(IN_W, ORDER, DECIM, DIFF_DELAY);
  localparam int        SHIFT = ACC_W - OUT_W;
  localparam int        PH_W  = cic_clog2(DECIM);
  localparam cic_mode_e MODE  = cic_mode(IN_W);

  if (ORDER < 1 || ORDER > CIC_MAX_ORDER) begin : g_bad_order
    $error("cic_decimator: ORDER out of range");
  end
  if (DECIM < 2 || DECIM > CIC_MAX_DECIM) begin : g_bad_decim
    $error("cic_decimator: DECIM out of range");
  end
  if (DIFF_DELAY < 1 || DIFF_DELAY > 2) begin : g_bad_delay
    $error("cic_decimator: DIFF_DELAY must be 1 or 2");
  end

  logic signed [ACC_W-1:0] x_ext;

  if (MODE == CIC_MODE_PDM) begin : g_pdm
    assign x_ext = bus.din[0] ? ACC_W'(1) : {ACC_W{1'b1}};
  end else begin : g_pcm
    assign x_ext = {{(ACC_W-IN_W){bus.din[IN_W-1]}}, bus.din};
  end

  // Integrators wrap modulo 2^ACC_W; the comb differences recover the true value.
  logic signed [ACC_W-1:0] integ [ORDER];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) integ[k] <= '0;
    end else if (bus.in_valid) begin
      integ[0] <= integ[0] + x_ext;
      for (int k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  logic [PH_W-1:0] phase;
  logic            phase_last;
  logic            blk_done;

  assign phase_last = (phase == PH_W'(DECIM - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      blk_done <= 1'b0;
    end else begin
      blk_done <= bus.in_valid && !bus.phase_clr && phase_last;
      if (bus.phase_clr) begin
        phase <= bus.in_valid ? PH_W'(1) : '0;
      end else if (bus.in_valid) begin
        phase <= phase_last ? '0 : phase + PH_W'(1);
      end
    end
  end

  // vld[k] enables comb stage k; vld[ORDER] is the output strobe.
  logic signed [ACC_W-1:0] dec_q;
  logic [ORDER:0]          vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q <= '0;
      vld   <= '0;
    end else begin
      vld <= {vld[ORDER-1:0], blk_done};
      if (blk_done) dec_q <= integ[ORDER-1];
    end
  end

  logic [ORDER:0][ACC_W-1:0] cx;
  assign cx[0] = dec_q;

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    cic_comb_stage #(
      .W          (ACC_W),
      .DIFF_DELAY (DIFF_DELAY)
    ) u_comb (
      .clk   (clk),
      .reset (reset),
      .en    (vld[k]),
      .x     (cx[k]),
      .y     (cx[k+1])
    );
  end

  logic signed [ACC_W-1:0] c_out;
  assign c_out         = cx[ORDER];
  assign bus.out_valid = vld[ORDER];

  // Scaling is combinational on the last comb register, so dout holds between strobes.
  if (SHIFT > 0) begin : g_shift
`ifdef CIC_ROUND_EN
    logic signed [ACC_W:0] rnd;
    logic signed [OUT_W:0] rq;
    logic                  unused_rnd_lsbs;

    assign rnd = {c_out[ACC_W-1], c_out} + ((ACC_W+1)'(1) << (SHIFT - 1));
    assign rq  = rnd[ACC_W:SHIFT];
    assign bus.dout = (!rq[OUT_W] && rq[OUT_W-1]) ? {1'b0, {(OUT_W-1){1'b1}}}
                                                  : rq[OUT_W-1:0];
    assign unused_rnd_lsbs = ^rnd[SHIFT-1:0];
`else
    logic unused_trunc_lsbs;

    assign bus.dout          = c_out[ACC_W-1:SHIFT];
    assign unused_trunc_lsbs = ^c_out[SHIFT-1:0];
`endif
  end else begin : g_extend
    assign bus.dout = OUT_W'(c_out);
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench: default PDM filter against a block-level model, plus a 16-bit PCM configuration.
module tb_cic_decimator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cic_decimator_if #(.IN_W(1),  .OUT_W(24)) bus ();
  cic_decimator_if #(.IN_W(16), .OUT_W(12)) bus2 ();

  cic_decimator #(
    .IN_W(1), .ORDER(2), .DECIM(49), .DIFF_DELAY(1), .OUT_W(24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cic_decimator #(
    .IN_W(16), .ORDER(3), .DECIM(4), .DIFF_DELAY(1), .OUT_W(12)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model of the default build: ORDER=2, DECIM=49, M=1, ACC_W=14, output sign-extended.
  typedef struct {
    longint val;
    int     cyc;
  } exp_t;

  exp_t q[$];
  int   m_i0, m_i1, m_d0, m_d1, m_ph;
  int   cyc = 0;
  int   n_out = 0;
  int   n_out2 = 0;
  bit   pdm [980];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sx14(input int v);
    logic signed [13:0] t;
    t = v[13:0];
    return longint'(t);
  endfunction

  task automatic model_clear();
    m_i0 = 0; m_i1 = 0; m_d0 = 0; m_d1 = 0; m_ph = 0;
    q.delete();
  endtask

  // Drives one cycle on the default DUT and advances the model alongside it.
  task automatic step(input logic v, input logic d, input logic clr);
    int   x, c0, c1;
    bit   done;
    exp_t e;
    bus.in_valid  = v;
    bus.din       = d;
    bus.phase_clr = clr;
    if (v) begin
      x    = d ? 1 : -1;
      done = (m_ph == 48) && !clr;
      m_i1 = m_i1 + m_i0;
      m_i0 = m_i0 + x;
      if (clr)       m_ph = 1;
      else if (done) m_ph = 0;
      else           m_ph = m_ph + 1;
      if (done) begin
        c0   = m_i1 - m_d0;
        m_d0 = m_i1;
        c1   = c0 - m_d1;
        m_d1 = c0;
        e.val = sx14(c1);
        e.cyc = cyc + 4;
        q.push_back(e);
      end
    end else if (clr) begin
      m_ph = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.din        = 1'b0;
    bus.phase_clr  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.din       = '0;
    bus2.phase_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    repeat (6) step(1'b0, 1'b0, 1'b0);
    chk("queue_drained", q.size(), 0);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.out_valid) begin
        n_out++;
        if (q.size() == 0) begin
          chk("spurious_strobe", bus.out_valid, 0);
        end else begin
          mon_e = q.pop_front();
          chk("dout", longint'(bus.dout), mon_e.val);
          chk("strobe_cycle", cyc, mon_e.cyc);
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        chk("missing_strobe", bus.out_valid, 1);
        void'(q.pop_front());
      end
      if (bus2.out_valid) n_out2++;
    end
  end

  int base;
  longint pcm_exp;

  initial begin
    do_reset();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_dout", longint'(bus.dout), 0);
    chk("rst_out_valid2", bus2.out_valid, 0);
    chk("rst_dout2", longint'(bus2.dout), 0);

    // PDM all-ones: outputs 1176 then steady +2401.
    base = n_out;
    repeat (490) step(1'b1, 1'b1, 1'b0);
    drain();
    chk("ones_count", n_out - base, 10);
    chk("ones_dout", longint'(bus.dout), 2401);

    // PDM all-zeros over 2^16 samples: integrators wrap, output stays -2401.
    do_reset();
    base = n_out;
    repeat (65536) step(1'b1, 1'b0, 1'b0);
    drain();
    chk("zeros_count", n_out - base, 1337);
    chk("zeros_dout", longint'(bus.dout), -2401);

    // Random PDM, dense then every third cycle with junk din while idle.
    for (int i = 0; i < 980; i++) pdm[i] = 1'($urandom_range(0, 1));
    do_reset();
    base = n_out;
    for (int i = 0; i < 980; i++) step(1'b1, pdm[i], 1'b0);
    drain();
    chk("dense_count", n_out - base, 20);
    do_reset();
    base = n_out;
    for (int i = 0; i < 980; i++) begin
      step(1'b1, pdm[i], 1'b0);
      step(1'b0, pdm[(i + 7) % 980], 1'b0);
      step(1'b0, pdm[(i + 13) % 980], 1'b0);
    end
    drain();
    chk("sparse_count", n_out - base, 20);

    // Reset after a partial block: a full fresh block is needed.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, pdm[i], 1'b0);
    step(1'b0, 1'b0, 1'b0);
    do_reset();
    base = n_out;
    for (int i = 0; i < 48; i++) step(1'b1, pdm[i], 1'b0);
    drain();
    chk("rst_partial_none", n_out - base, 0);
    step(1'b1, pdm[48], 1'b0);
    drain();
    chk("rst_partial_one", n_out - base, 1);

    // phase_clr with a sample at phase 30: that sample opens the new block.
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, pdm[i], 1'b0);
    base = n_out;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 47; i++) step(1'b1, pdm[i + 100], 1'b0);
    drain();
    chk("clr_valid_47", n_out - base, 0);
    step(1'b1, 1'b0, 1'b0);
    drain();
    chk("clr_valid_48", n_out - base, 1);

    // phase_clr alone: full 49 accepts to the next output.
    for (int i = 0; i < 10; i++) step(1'b1, pdm[i + 200], 1'b0);
    step(1'b0, 1'b1, 1'b1);
    base = n_out;
    for (int i = 0; i < 48; i++) step(1'b1, pdm[i + 300], 1'b0);
    drain();
    chk("clr_alone_48", n_out - base, 0);
    step(1'b1, 1'b1, 1'b0);
    drain();
    chk("clr_alone_49", n_out - base, 1);

    // PCM config, SHIFT=10: 1000*64/1024 = 62.5; 32767*64/1024 saturates/truncates to 2047.
    do_reset();
`ifdef CIC_ROUND_EN
    pcm_exp = 63;
`else
    pcm_exp = 62;
`endif
    base = n_out2;
    bus2.in_valid = 1'b1;
    bus2.din      = 16'd1000;
    repeat (40) step(1'b0, 1'b0, 1'b0);
    bus2.in_valid = 1'b0;
    repeat (8) step(1'b0, 1'b0, 1'b0);
    chk("pcm_count", n_out2 - base, 10);
    chk("pcm_1000", longint'(bus2.dout), pcm_exp);
    bus2.in_valid = 1'b1;
    bus2.din      = 16'd32767;
    repeat (40) step(1'b0, 1'b0, 1'b0);
    bus2.in_valid = 1'b0;
    repeat (8) step(1'b0, 1'b0, 1'b0);
    chk("pcm_32767", longint'(bus2.dout), 2047);
    chk("pcm_count2", n_out2 - base, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
